// File: rtl/aud_ctrl_pkg.sv
// Shared types for the audio session controller: FSM state encoding, command enum and
// the default SRAM address width.
package aud_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 20;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC        = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_START,
        CMD_PAUSE,
        CMD_STOP
    } cmd_e;

endpackage

// File: rtl/aud_cmd_arb.sv
// Priority encoder from key pulses (plus internal autostop) to a single command.
// Order: stop key > pause key > start key > autostop.
module aud_cmd_arb
    import aud_ctrl_pkg::*;
(
    input  logic i_key_start,
    input  logic i_key_pause,
    input  logic i_key_stop,
    input  logic i_autostop,
    output cmd_e o_cmd
);

    always_comb begin
        o_cmd = CMD_NONE;
        if (i_key_stop) begin
            o_cmd = CMD_STOP;
        end else if (i_key_pause) begin
            o_cmd = CMD_PAUSE;
        end else if (i_key_start) begin
            o_cmd = CMD_START;
        end else if (i_autostop) begin
            o_cmd = CMD_STOP;
        end
    end

endmodule

// File: rtl/aud_session_ctrl.sv
// Record/playback session FSM with registered command pulses and SRAM arbitration.
// Define AUD_CTRL_AUTOSTOP_EN to stop recording automatically at MAX_ADDR.
module aud_session_ctrl
    import aud_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_start,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_rec_address,
    input  logic              i_dsp_done,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_has_rec,
    output logic              o_sram_sel,
    output logic [2:0]        o_state
);

`ifdef AUD_CTRL_AUTOSTOP_EN
    localparam bit AutostopEn = 1'b1;
`else
    localparam bit AutostopEn = 1'b0;
`endif

    state_e            state_q, state_d;
    cmd_e              cmd;
    logic              autostop;
    logic              rec_start_d, rec_pause_d, rec_stop_d;
    logic              dsp_start_d, dsp_pause_d, dsp_stop_d;
    logic [ADDR_W-1:0] end_addr_d;
    logic              has_rec_d, sram_sel_d;

    assign autostop = AutostopEn && (state_q == REC) && (i_rec_address == MAX_ADDR);

    aud_cmd_arb u_arb (
        .i_key_start (i_key_start),
        .i_key_pause (i_key_pause),
        .i_key_stop  (i_key_stop),
        .i_autostop  (autostop),
        .o_cmd       (cmd)
    );

    always_comb begin
        state_d     = state_q;
        rec_start_d = 1'b0;
        rec_pause_d = 1'b0;
        rec_stop_d  = 1'b0;
        dsp_start_d = 1'b0;
        dsp_pause_d = 1'b0;
        dsp_stop_d  = 1'b0;
        end_addr_d  = o_end_addr;
        has_rec_d   = o_has_rec;
        sram_sel_d  = o_sram_sel;
        unique case (state_q)
            IDLE: begin
                if (cmd == CMD_START && !i_mode) begin
                    state_d     = REC;
                    rec_start_d = 1'b1;
                    sram_sel_d  = 1'b0;
                    has_rec_d   = 1'b0;
                end else if (cmd == CMD_START && o_has_rec) begin
                    state_d     = PLAY;
                    dsp_start_d = 1'b1;
                    sram_sel_d  = 1'b1;
                end
            end
            REC, REC_PAUSE: begin
                if (cmd == CMD_STOP) begin
                    state_d    = IDLE;
                    rec_stop_d = 1'b1;
                    end_addr_d = i_rec_address;
                    has_rec_d  = 1'b1;
                end else if (cmd == CMD_PAUSE && state_q == REC) begin
                    state_d     = REC_PAUSE;
                    rec_pause_d = 1'b1;
                end else if (cmd == CMD_START && state_q == REC_PAUSE) begin
                    state_d     = REC;
                    rec_start_d = 1'b1;
                end
            end
            PLAY, PLAY_PAUSE: begin
                if (cmd == CMD_STOP) begin
                    state_d    = IDLE;
                    dsp_stop_d = 1'b1;
                end else if (cmd == CMD_PAUSE && state_q == PLAY) begin
                    state_d     = PLAY_PAUSE;
                    dsp_pause_d = 1'b1;
                end else if (cmd == CMD_START && state_q == PLAY_PAUSE) begin
                    state_d     = PLAY;
                    dsp_start_d = 1'b1;
                end else if (i_dsp_done && state_q == PLAY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            o_rec_start <= 1'b0;
            o_rec_pause <= 1'b0;
            o_rec_stop  <= 1'b0;
            o_dsp_start <= 1'b0;
            o_dsp_pause <= 1'b0;
            o_dsp_stop  <= 1'b0;
            o_end_addr  <= '0;
            o_has_rec   <= 1'b0;
            o_sram_sel  <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_rec_start <= rec_start_d;
            o_rec_pause <= rec_pause_d;
            o_rec_stop  <= rec_stop_d;
            o_dsp_start <= dsp_start_d;
            o_dsp_pause <= dsp_pause_d;
            o_dsp_stop  <= dsp_stop_d;
            o_end_addr  <= end_addr_d;
            o_has_rec   <= has_rec_d;
            o_sram_sel  <= sram_sel_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Directed self-checking bench for aud_session_ctrl; honours AUD_CTRL_AUTOSTOP_EN.
module tb_aud_session_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_key_start = 1'b0, i_key_pause = 1'b0, i_key_stop = 1'b0;
    logic        i_mode = 1'b0;
    logic [19:0] i_rec_address = '0;
    logic        i_dsp_done = 1'b0;
    logic        o_rec_start, o_rec_pause, o_rec_stop;
    logic        o_dsp_start, o_dsp_pause, o_dsp_stop;
    logic [19:0] o_end_addr;
    logic        o_has_rec, o_sram_sel;
    logic [2:0]  o_state;
    logic [5:0]  pulses;

    int vectors = 0;
    int miscompares = 0;

    // {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
    assign pulses = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};

    always #5 i_clk = ~i_clk;

    aud_session_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_key_start   (i_key_start),
        .i_key_pause   (i_key_pause),
        .i_key_stop    (i_key_stop),
        .i_mode        (i_mode),
        .i_rec_address (i_rec_address),
        .i_dsp_done    (i_dsp_done),
        .o_rec_start   (o_rec_start),
        .o_rec_pause   (o_rec_pause),
        .o_rec_stop    (o_rec_stop),
        .o_dsp_start   (o_dsp_start),
        .o_dsp_pause   (o_dsp_pause),
        .o_dsp_stop    (o_dsp_stop),
        .o_end_addr    (o_end_addr),
        .o_has_rec     (o_has_rec),
        .o_sram_sel    (o_sram_sel),
        .o_state       (o_state)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive keys for one edge, then release; outputs are sampled 1 time unit after the edge.
    task automatic press(input logic start, input logic pause, input logic stop);
        i_key_start = start;
        i_key_pause = pause;
        i_key_stop  = stop;
        tick();
        i_key_start = 1'b0;
        i_key_pause = 1'b0;
        i_key_stop  = 1'b0;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (pulses !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b want %b", pulses, 6'b000000);
        end
        vectors++;
        if (o_state !== 3'd0 || o_has_rec !== 1'b0 || o_sram_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got state=%0d has_rec=%b sel=%b want 0/0/0",
                     o_state, o_has_rec, o_sram_sel);
        end
        vectors++;
        if (o_end_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_end_addr: got %h want 00000", o_end_addr);
        end
    endtask

    task automatic test_play_without_rec();
        i_mode = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL play_no_rec: got pulses=%b state=%0d want 000000/0", pulses, o_state);
        end
    endtask

    task automatic test_record();
        i_mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pulses !== 6'b100000 || o_state !== 3'd1 || o_sram_sel !== 1'b0 || o_has_rec !== 1'b0)
        begin
            miscompares++;
            $display("FAIL rec_start: got pulses=%b state=%0d sel=%b has=%b want 100000/1/0/0",
                     pulses, o_state, o_sram_sel, o_has_rec);
        end
        tick();
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL rec_start_width: got pulses=%b state=%0d want 000000/1", pulses, o_state);
        end
        press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (pulses !== 6'b010000 || o_state !== 3'd2) begin
            miscompares++;
            $display("FAIL rec_pause: got pulses=%b state=%0d want 010000/2", pulses, o_state);
        end
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pulses !== 6'b100000 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL rec_resume: got pulses=%b state=%0d want 100000/1", pulses, o_state);
        end
        i_rec_address = 20'h00123;
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (pulses !== 6'b001000 || o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL rec_stop: got pulses=%b state=%0d want 001000/0", pulses, o_state);
        end
        vectors++;
        if (o_end_addr !== 20'h00123 || o_has_rec !== 1'b1) begin
            miscompares++;
            $display("FAIL rec_latch: got end=%h has=%b want 00123/1", o_end_addr, o_has_rec);
        end
    endtask

    task automatic test_play();
        i_mode = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pulses !== 6'b000100 || o_state !== 3'd3 || o_sram_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL dsp_start: got pulses=%b state=%0d sel=%b want 000100/3/1",
                     pulses, o_state, o_sram_sel);
        end
        press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (pulses !== 6'b000010 || o_state !== 3'd4) begin
            miscompares++;
            $display("FAIL dsp_pause: got pulses=%b state=%0d want 000010/4", pulses, o_state);
        end
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd4) begin
            miscompares++;
            $display("FAIL done_in_pause: got pulses=%b state=%0d want 000000/4", pulses, o_state);
        end
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (pulses !== 6'b000100 || o_state !== 3'd3) begin
            miscompares++;
            $display("FAIL dsp_resume: got pulses=%b state=%0d want 000100/3", pulses, o_state);
        end
        i_dsp_done = 1'b1;
        tick();
        i_dsp_done = 1'b0;
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd0 || o_sram_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL dsp_done: got pulses=%b state=%0d sel=%b want 000000/0/1",
                     pulses, o_state, o_sram_sel);
        end
        press(1'b0, 1'b1, 1'b0);
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_pause: got pulses=%b state=%0d want 000000/0", pulses, o_state);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (pulses !== 6'b000001 || o_state !== 3'd0 || o_has_rec !== 1'b1) begin
            miscompares++;
            $display("FAIL dsp_stop: got pulses=%b state=%0d has=%b want 000001/0/1",
                     pulses, o_state, o_has_rec);
        end
    endtask

    task automatic test_priority();
        i_mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (o_has_rec !== 1'b0 || o_sram_sel !== 1'b0 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL rerecord: got has=%b sel=%b state=%0d want 0/0/1",
                     o_has_rec, o_sram_sel, o_state);
        end
        i_rec_address = 20'h00456;
        press(1'b1, 1'b1, 1'b1);
        vectors++;
        if (pulses !== 6'b001000 || o_state !== 3'd0 || o_end_addr !== 20'h00456) begin
            miscompares++;
            $display("FAIL all_keys: got pulses=%b state=%0d end=%h want 001000/0/00456",
                     pulses, o_state, o_end_addr);
        end
    endtask

    task automatic test_autostop();
        i_mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        i_rec_address = 20'hFFFFF;
        tick();
`ifdef AUD_CTRL_AUTOSTOP_EN
        vectors++;
        if (pulses !== 6'b001000 || o_state !== 3'd0 || o_end_addr !== 20'hFFFFF
            || o_has_rec !== 1'b1) begin
            miscompares++;
            $display("FAIL autostop: got pulses=%b state=%0d end=%h has=%b want 001000/0/fffff/1",
                     pulses, o_state, o_end_addr, o_has_rec);
        end
`else
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL no_autostop: got pulses=%b state=%0d want 000000/1", pulses, o_state);
        end
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (pulses !== 6'b001000 || o_end_addr !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL max_stop: got pulses=%b end=%h want 001000/fffff", pulses, o_end_addr);
        end
`endif
        i_rec_address = 20'h00010;
    endtask

    task automatic test_reset_mid_play();
        i_mode = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        vectors++;
        if (o_state !== 3'd3 || o_sram_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_play: got state=%0d sel=%b want 3/1", o_state, o_sram_sel);
        end
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd0 || o_has_rec !== 1'b0 || o_sram_sel !== 1'b0)
        begin
            miscompares++;
            $display("FAIL reset_mid_play: got pulses=%b state=%0d has=%b sel=%b want 000000/0/0/0",
                     pulses, o_state, o_has_rec, o_sram_sel);
        end
        tick();
        vectors++;
        if (pulses !== 6'b000000 || o_end_addr !== 20'h0) begin
            miscompares++;
            $display("FAIL post_reset: got pulses=%b end=%h want 000000/00000", pulses, o_end_addr);
        end
    endtask

    task automatic test_back_to_back();
        i_mode = 1'b0;
        i_key_start = 1'b1;
        tick();
        vectors++;
        if (pulses !== 6'b100000 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL held_start_1: got pulses=%b state=%0d want 100000/1", pulses, o_state);
        end
        tick();
        i_key_start = 1'b0;
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd1) begin
            miscompares++;
            $display("FAIL held_start_2: got pulses=%b state=%0d want 000000/1", pulses, o_state);
        end
        i_key_pause = 1'b1;
        tick();
        tick();
        i_key_pause = 1'b0;
        vectors++;
        if (pulses !== 6'b000000 || o_state !== 3'd2) begin
            miscompares++;
            $display("FAIL held_pause: got pulses=%b state=%0d want 000000/2", pulses, o_state);
        end
        i_rec_address = 20'h0ABCD;
        press(1'b0, 1'b0, 1'b1);
        vectors++;
        if (pulses !== 6'b001000 || o_end_addr !== 20'h0ABCD || o_has_rec !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_stop: got pulses=%b end=%h has=%b want 001000/0abcd/1",
                     pulses, o_end_addr, o_has_rec);
        end
    endtask

    initial begin
        test_reset();
        test_play_without_rec();
        test_record();
        test_play();
        test_priority();
        test_autostop();
        test_reset_mid_play();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
